// File: rtl/nn_frame_sequencer.sv
// Frame sequencer for the digit-recognition network: buffers one image, clears the
// network, replays the frame as fixed-point samples, then hands back the predicted digit.
module nn_frame_sequencer #(
   parameter int BITS  = 24,
   parameter int FRAC  = 16,
   parameter int WIDTH = 784,
   parameter int DRAIN = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            pix_valid,
   output logic            pix_ready,
   input  logic [7:0]      pix_data,
   output logic            nn_clr,
   output logic            nn_en,
   output logic [BITS-1:0] nn_pixel,
   input  logic [BITS-1:0] nn_result,
   output logic            res_valid,
   input  logic            res_ready,
   output logic [3:0]      res_digit,
   output logic            busy
);

   localparam int            AW         = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [AW-1:0] LAST_IDX   = AW'(WIDTH - 1);
   localparam logic [3:0]    LAST_DRAIN = 4'(DRAIN - 1);

   typedef enum logic [2:0] {
      S_LOAD,
      S_CLEAR,
      S_STREAM,
      S_DRAIN,
      S_RESULT
   } state_t;

   state_t          state;
   logic [AW-1:0]   wr_idx;
   logic [AW-1:0]   rd_idx;
   logic [3:0]      drain_cnt;
   logic            clr_q;
   logic            en_q;
   logic            res_valid_q;
   logic [3:0]      res_digit_q;
   logic            pix_ready_q;
   logic            busy_q;

   logic [7:0]      buffer [WIDTH];
   logic [7:0]      pix_q;
   logic            load_fire;
   logic            fetch;
   logic [AW-1:0]   fetch_idx;
   logic [BITS-1:0] sample;

   assign load_fire = pix_valid && pix_ready_q;

   // Sample k is fetched one cycle ahead (buffer[0] during CLEAR) so STREAM has no bubbles.
   always_comb begin
      fetch     = 1'b0;
      fetch_idx = '0;
      if (state == S_CLEAR) begin
         fetch = 1'b1;
      end else if (state == S_STREAM && rd_idx != LAST_IDX) begin
         fetch     = 1'b1;
         fetch_idx = rd_idx + 1'b1;
      end
   end

   // NOTE: the frame buffer has no reset; a reset only aborts the frame and every entry
   // is rewritten by the next LOAD before it is read.
   always_ff @(posedge clk) begin
      if (load_fire)
         buffer[wr_idx] <= pix_data;
      if (fetch)
         pix_q <= buffer[fetch_idx];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= S_LOAD;
         wr_idx      <= '0;
         rd_idx      <= '0;
         drain_cnt   <= '0;
         clr_q       <= 1'b0;
         en_q        <= 1'b0;
         res_valid_q <= 1'b0;
         res_digit_q <= '0;
         pix_ready_q <= 1'b1;
         busy_q      <= 1'b0;
      end else begin
         case (state)
            S_LOAD: begin
               if (load_fire) begin
                  if (wr_idx == LAST_IDX) begin
                     wr_idx      <= '0;
                     clr_q       <= 1'b1;
                     pix_ready_q <= 1'b0;
                     busy_q      <= 1'b1;
                     state       <= S_CLEAR;
                  end else begin
                     wr_idx <= wr_idx + 1'b1;
                  end
               end
            end
            S_CLEAR: begin
               clr_q  <= 1'b0;
               en_q   <= 1'b1;
               rd_idx <= '0;
               state  <= S_STREAM;
            end
            S_STREAM: begin
               if (rd_idx == LAST_IDX) begin
                  rd_idx    <= '0;
                  en_q      <= 1'b0;
                  drain_cnt <= '0;
                  state     <= S_DRAIN;
               end else begin
                  rd_idx <= rd_idx + 1'b1;
               end
            end
            S_DRAIN: begin
               if (drain_cnt == LAST_DRAIN) begin
                  res_digit_q <= nn_result[3:0];
                  res_valid_q <= 1'b1;
                  state       <= S_RESULT;
               end else begin
                  drain_cnt <= drain_cnt + 1'b1;
               end
            end
            S_RESULT: begin
               if (res_ready) begin
                  res_valid_q <= 1'b0;
                  pix_ready_q <= 1'b1;
                  busy_q      <= 1'b0;
                  state       <= S_LOAD;
               end
            end
            default: state <= S_LOAD;
         endcase
      end
   end

   assign sample = {{(BITS-8){1'b0}}, pix_q} << (FRAC - 8);

   // NOTE: the network strobes are masked by reset so an aborted frame never emits
   // an nn_en or nn_clr pulse in the cycle reset is sampled.
   assign nn_clr    = clr_q && !reset;
   assign nn_en     = en_q && !reset;
   assign nn_pixel  = (en_q && !reset) ? sample : '0;
   assign pix_ready = pix_ready_q;
   assign res_valid = res_valid_q;
   assign res_digit = res_digit_q;
   assign busy      = busy_q;

   logic unused_result_hi;
   assign unused_result_hi = ^nn_result[BITS-1:4];

endmodule

// File: tb/tb_nn_frame_sequencer.sv
// Scoreboard bench for nn_frame_sequencer: loads frames, predicts the replayed stream
// and the captured digit, and compares them against what the sequencer presents.
module tb_nn_frame_sequencer;

   localparam int BITS  = 24;
   localparam int FRAC  = 16;
   localparam int WIDTH = 784;
   localparam int DRAIN = 4;

   logic            clk       = 1'b0;
   logic            reset     = 1'b1;
   logic            pix_valid = 1'b0;
   logic            pix_ready;
   logic [7:0]      pix_data  = '0;
   logic            nn_clr;
   logic            nn_en;
   logic [BITS-1:0] nn_pixel;
   logic [BITS-1:0] nn_result = '0;
   logic            res_valid;
   logic            res_ready = 1'b0;
   logic [3:0]      res_digit;
   logic            busy;

   nn_frame_sequencer #(
      .BITS(BITS), .FRAC(FRAC), .WIDTH(WIDTH), .DRAIN(DRAIN)
   ) dut (
      .clk(clk), .reset(reset),
      .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
      .nn_clr(nn_clr), .nn_en(nn_en), .nn_pixel(nn_pixel), .nn_result(nn_result),
      .res_valid(res_valid), .res_ready(res_ready), .res_digit(res_digit),
      .busy(busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
   endtask

   // Reference model: the stream is the accepted pixels in order, each scaled p/256 in Q.FRAC.
   logic [BITS-1:0] exp_pix[$];
   logic [3:0]      exp_digit[$];
   bit              lin_mode  = 1'b0;
   bit              force_abc = 1'b0;
   int              acc_cyc   = 0;

   // Network stand-in: random prediction every cycle; the value present in the DRAIN-th
   // cycle after a full-length enable run is the one the sequencer must capture.
   int run_d = 0, last_run = 0, since_en = 99;
   always @(negedge clk) begin
      logic [BITS-1:0] v;
      v = BITS'($urandom);
      if (reset) begin
         run_d = 0; last_run = 0; since_en = 99;
      end else if (nn_en) begin
         run_d++; since_en = 0;
      end else begin
         if (since_en < 99) since_en++;
         if (run_d != 0) begin last_run = run_d; run_d = 0; end
         if (since_en == DRAIN && last_run == WIDTH) begin
            if (force_abc) v = 24'hABC007;
            exp_digit.push_back(v[3:0]);
         end
      end
      nn_result = v;
   end

   // Monitor: compares whatever the DUT presents against the queued expectations.
   int run_m = 0;
   bit en_prev = 1'b0, clr_prev = 1'b0;
   always @(negedge clk) begin
      if (reset) begin
         run_m = 0; en_prev = 1'b0; clr_prev = 1'b0;
      end else begin
         if (nn_en) begin
            if (!en_prev) check("clr_before_stream", 32'(clr_prev), 1);
            if (exp_pix.size() == 0) check("sample_expected", 0, 1);
            else check("nn_pixel", nn_pixel, exp_pix.pop_front());
            if (lin_mode && run_m == 255) check("pix_255", nn_pixel, 24'h00FF00);
            if (lin_mode && run_m == 256) check("pix_256", nn_pixel, 24'h000000);
            check("no_en_in_load", 32'(pix_ready), 0);
            run_m++;
         end else begin
            check("pixel_idle_zero", nn_pixel, 0);
            if (en_prev) begin
               check("en_run_length", run_m, WIDTH);
               run_m = 0;
            end
         end
         if (clr_prev) check("clr_one_cycle", 32'(nn_clr), 0);
         if (res_valid && res_ready) begin
            if (exp_digit.size() == 0) check("digit_expected", 0, 1);
            else check("res_digit", res_digit, exp_digit.pop_front());
         end
         en_prev  = nn_en;
         clr_prev = nn_clr;
      end
   end

   task automatic check_reset_vals(input string tag);
      check({tag, "_pix_ready"}, 32'(pix_ready), 1);
      check({tag, "_nn_clr"},    32'(nn_clr), 0);
      check({tag, "_nn_en"},     32'(nn_en), 0);
      check({tag, "_nn_pixel"},  nn_pixel, 0);
      check({tag, "_res_valid"}, 32'(res_valid), 0);
      check({tag, "_res_digit"}, res_digit, 0);
      check({tag, "_busy"},      32'(busy), 0);
   endtask

   task automatic apply_reset();
      @(posedge clk); #1 reset = 1'b1;
      @(negedge clk);
      check("rst_same_cycle_en",  32'(nn_en), 0);
      check("rst_same_cycle_clr", 32'(nn_clr), 0);
      repeat (2) begin
         @(negedge clk);
         check_reset_vals("rst");
      end
      @(posedge clk); #1 reset = 1'b0;
      exp_pix.delete();
      exp_digit.delete();
      @(negedge clk);
      check("post_rst_pix_ready", 32'(pix_ready), 1);
      check("post_rst_busy", 32'(busy), 0);
   endtask

   // mode 0: k mod 256, mode 1: all 255, mode 2: random. n pixels, optionally throttled.
   task automatic load_frame(input int mode, input int n, input bit throttle);
      int k = 0, t = 0, duty;
      logic [7:0] p;
      duty = throttle ? int'($urandom_range(1, 2)) : 3;
      lin_mode = (mode == 0);
      while (k < n && t < 4 * WIDTH) begin
         case (mode)
            0:       p = 8'(k % 256);
            1:       p = 8'd255;
            default: p = 8'($urandom_range(0, 255));
         endcase
         @(posedge clk); #1;
         pix_valid = ((t % 3) < duty);
         pix_data  = p;
         @(negedge clk);
         if (pix_valid && pix_ready) begin
            exp_pix.push_back(BITS'(int'(p) * (2 ** (FRAC - 8))));
            if (k == WIDTH - 1) acc_cyc = cyc;
            k++;
         end
         t++;
      end
      if (k < n) check("load_timeout", k, n);
      @(posedge clk); #1 pix_valid = 1'b0;
   endtask

   task automatic take_result(input int hold, input bit expect7);
      bit seen = 1'b0;
      logic [3:0] d0;
      for (int t = 0; t < 3000 && !seen; t++) begin
         @(negedge clk);
         seen = res_valid;
      end
      check("res_valid_seen", 32'(seen), 1);
      if (!seen) return;
      check("result_latency", cyc - acc_cyc - 1, 1 + WIDTH + DRAIN);
      check("busy_in_result", 32'(busy), 1);
      if (expect7) check("digit_abc007", res_digit, 7);
      d0 = res_digit;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check("res_digit_stable", res_digit, d0);
         check("pix_ready_low_in_result", 32'(pix_ready), 0);
      end
      @(posedge clk); #1;
      res_ready = 1'b1;
      pix_valid = 1'b1;
      pix_data  = 8'h5A;
      @(negedge clk);
      @(posedge clk); #1;
      res_ready = 1'b0;
      pix_valid = 1'b0;
      @(negedge clk);
      check("pix_ready_after_hs", 32'(pix_ready), 1);
      check("res_valid_after_hs", 32'(res_valid), 0);
      check("busy_after_hs", 32'(busy), 0);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      check_reset_vals("init");
      @(posedge clk); #1 reset = 1'b0;
      @(negedge clk);
      check("init_pix_ready", 32'(pix_ready), 1);

      // Partial load, then reset from that state.
      load_frame(2, 100, 1'b0);
      apply_reset();

      // Linear frame, gap-free, forced prediction word, result held for 10 cycles.
      force_abc = 1'b1;
      load_frame(0, WIDTH, 1'b0);
      take_result(10, 1'b1);
      force_abc = 1'b0;

      // Back-to-back frame of all 255.
      load_frame(1, WIDTH, 1'b0);
      take_result(3, 1'b0);

      // Linear frame with throttled input.
      load_frame(0, WIDTH, 1'b1);
      take_result(2, 1'b0);

      // Random throttled frame aborted by reset at enabled cycle 400.
      load_frame(2, WIDTH, 1'b1);
      begin
         int cnt = 0, t = 0;
         while (cnt < 400 && t < 3000) begin
            @(negedge clk);
            if (nn_en) cnt++;
            t++;
         end
         check("reached_en_400", cnt, 400);
      end
      apply_reset();

      // Full random frame after the abort.
      load_frame(2, WIDTH, 1'b0);
      take_result(1, 1'b0);

      repeat (3) @(negedge clk);
      check("scoreboard_pix_empty", exp_pix.size(), 0);
      check("scoreboard_digit_empty", exp_digit.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #(60000 * 10);
      $display("FAIL watchdog: simulation did not finish, checks %0d/%0d", n_pass, n_checks);
      $fatal(1);
   end

endmodule

// File: doc/nn_frame_sequencer.md
# nn_frame_sequencer

Upstream controller for the digit-recognition network. Accepts one 28×28 image as a stream of 8-bit grayscale pixels and stores it in an internal frame buffer. It then clears the network accumulators, replays the frame as fixed-point samples with an enable strobe for exactly one pass, waits for the network to settle and captures the predicted digit behind a valid/ready result handshake.

## Interface
Parameters:
- BITS, 24: width of the fixed-point sample driven to the network and of the returned prediction word.
- FRAC, 16: fractional bits of the sample format; must satisfy 8 ≤ FRAC ≤ BITS-1.
- WIDTH, 784: pixels per frame, i.e. frame buffer depth.
- DRAIN, 4: cycles waited after the last enabled cycle before the prediction is sampled; legal range 1..15.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- pix_valid  in  1  input pixel valid.
- pix_ready  out  1  sequencer accepts a pixel this cycle.
- pix_data  in  8  unsigned grayscale pixel, 0..255.
- nn_clr  out  1  one-cycle accumulator/counter clear to the network.
- nn_en  out  1  network enable; high for exactly WIDTH cycles per frame.
- nn_pixel  out  BITS  fixed-point sample for the current enabled cycle.
- nn_result  in  BITS  prediction word from the network; digit in bits [3:0].
- res_valid  out  1  captured prediction available.
- res_ready  in  1  consumer takes the prediction.
- res_digit  out  4  captured prediction, nn_result[3:0].
- busy  out  1  high in every state except LOAD.

## Operation
- States and transitions:
  - LOAD → CLEAR when the WIDTH-th pixel is accepted.
  - CLEAR → STREAM after exactly one cycle.
  - STREAM → DRAIN when the read index reaches WIDTH-1 with nn_en high.
  - DRAIN → RESULT after DRAIN cycles.
  - RESULT → LOAD on res_valid && res_ready.
- LOAD:
  - pix_ready = 1.
  - A transfer occurs when pix_valid && pix_ready. The pixel is written to buffer[wr_idx] and wr_idx increments.
  - pix_valid low stalls without side effects.
- CLEAR: nn_clr = 1 for one cycle; read index is 0.
- STREAM:
  - nn_en = 1.
  - nn_pixel = zero-extended buffer[rd_idx] << (FRAC-8). Pixel value p maps to p/256 in Q(BITS-FRAC).FRAC. Upper bits are zero and there is no sign bit set.
  - rd_idx increments each cycle. The buffer is read combinationally or pre-fetched, so no bubbles occur.
- DRAIN: nn_en = 0, nn_pixel = 0. A 4-bit counter counts DRAIN cycles. On the final cycle, nn_result[3:0] is registered into res_digit.
- RESULT:
  - res_valid = 1.
  - res_digit is held stable until the handshake completes.
  - pix_ready = 0: the next image is not accepted until the result is taken.
- Indices wrap to 0 on leaving LOAD and leaving STREAM. Only indices 0..WIDTH-1 are ever used.
- nn_result bits above [3:0] are ignored.

## Timing
- Reset values, held while reset is high: state = LOAD, wr_idx = 0, rd_idx = 0, pix_ready = 1 from the first cycle after reset, nn_clr = 0, nn_en = 0, nn_pixel = 0, res_valid = 0, res_digit = 0, busy = 0.
- Reset asserted mid-frame in any state aborts the frame. The buffer contents are don't-care and are not cleared. No nn_en or nn_clr pulse is emitted on the cycle reset is high.
- The first nn_en cycle is the cycle immediately after the nn_clr cycle, carrying buffer[0]. The k-th nn_en cycle carries buffer[k].
- Latency from the cycle the last pixel is accepted to res_valid rising is 1 (CLEAR) + WIDTH (STREAM) + DRAIN cycles, i.e. 789 with defaults.
- res_valid && res_ready in RESULT means pix_ready rises on the next cycle. A pixel offered in that same handshake cycle is not accepted.
- Gap-free input at one pixel per cycle fills the buffer in WIDTH cycles. Stalls extend LOAD only.
- busy goes high the cycle after the last pixel is accepted and goes low the cycle after the result handshake.

## Test plan
- Reset check: assert reset for 3 cycles from random state → all outputs at reset values; pix_ready = 1 the first cycle after release.
- Linear frame: pixels k mod 256 for k = 0..783, gap-free, with FRAC = 16 → exactly 1 nn_clr pulse, then exactly 784 consecutive nn_en cycles.
  - nn_pixel on enabled cycle k = (k mod 256) << 8.
  - Enabled cycle 255 gives 0x00FF00.
  - Enabled cycle 256 gives 0x000000.
- Throttled input: pix_valid toggled with period 3 and a random duty → buffer order preserved; stream identical to the gap-free case; no nn_en during LOAD.
- Result capture: drive nn_result = 0xABC007 in the last DRAIN cycle with DRAIN = 4 → res_digit = 7. res_valid rises 789 cycles after the last accept. Hold res_ready low for 10 cycles → res_digit stable, pix_ready = 0.
- Back-to-back frames: complete the handshake, then load a second frame of all 255 → pix_ready rises 1 cycle after the handshake. Second stream is nn_pixel = 0x00FF00 for all 784 enabled cycles, preceded by a fresh nn_clr.
- Mid-stream reset: assert reset at enabled cycle 400 → nn_en is 0 the same cycle reset is high. The FSM returns to LOAD and the next full frame streams 784 enabled cycles starting from index 0.
